heartbeat_ctrl: RTL and testbench

Wishbone-configurable sequencer that drives the user-area heartbeat output on a Caravel user GPIO.
- Programmable prescaler generates a tick; each tick advances one of two sources:
  - an 8-bit free-running counter (its MSB is the output), or
  - a programmable 1..32-bit blink pattern, played in repeat or one-shot mode.
- Sits inside user_project_wrapper on the Wishbone slave port. Drives one io_out bit and user_irq[0].

---
 rtl/heartbeat_ctrl_pkg.sv | 45 ++++
 rtl/heartbeat_ctrl_if.sv | 23 ++
 rtl/heartbeat_ctrl_prescaler.sv | 27 ++
 rtl/heartbeat_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_heartbeat_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/heartbeat_ctrl_pkg.sv
// rtl/heartbeat_ctrl_pkg.sv - shared register map, field positions and FSM encoding
package heartbeat_ctrl_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DIV     = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_LEN_LO  = 4;
    localparam int CTRL_LEN_HI  = 8;

    localparam logic [31:0] CTRL_MASK = 32'h0000_01F7;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_IDX_LO = 8;
    localparam int STAT_CNT_LO = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } hb_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] status_word(input logic       busy,
                                                input logic       done,
                                                input logic [4:0] idx,
                                                input logic [7:0] count);
        return {8'h00, count, 3'b000, idx, 6'b000000, done, busy};
    endfunction

endpackage

// File: rtl/heartbeat_ctrl_if.sv
// rtl/heartbeat_ctrl_if.sv - Wishbone slave bundle for the heartbeat sequencer
interface heartbeat_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/heartbeat_ctrl_prescaler.sv
// rtl/heartbeat_ctrl_prescaler.sv - reload down-counter producing the sequencer tick
module heartbeat_prescaler #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Restart holds the count at div, so the first tick lands div+1 cycles after release.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == '0)) begin
            r_cnt <= div;
        end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

    assign tick = !restart && (r_cnt == '0);

endmodule

// File: rtl/heartbeat_ctrl.sv
// rtl/heartbeat_ctrl.sv - Wishbone-configured heartbeat counter / blink-pattern sequencer
module heartbeat_ctrl
    import heartbeat_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          DIV_WIDTH = 24
) (
    input  logic            clk,
    input  logic            nreset,
    heartbeat_ctrl_if.slave wb,
    output logic            out,
    output logic            irq
);

    localparam logic [31:0] DIV_MASK = 32'((64'd1 << DIV_WIDTH) - 64'd1);

    logic [31:0] r_ctrl;
    logic [31:0] r_div;
    logic [31:0] r_pattern;
    logic        r_done;
    hb_state_t   r_state;
    logic [4:0]  r_idx;
    logic [7:0]  r_count;
    logic        r_ack;
    logic [31:0] r_dat;

    logic [1:0]  w_off;
    logic        w_hit;
    logic        w_req;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_div_new;
    logic [31:0] w_pattern_new;
    logic [31:0] w_rd_data;
    logic        w_en;
    logic        w_mode;
    logic        w_oneshot;
    logic [4:0]  w_len;
    logic        w_restart;
    logic        w_presc_restart;
    logic        w_tick;
    logic        w_done_set;
    logic        w_done_clr;
    hb_state_t   w_state_nx;
    logic [4:0]  w_idx_nx;
    logic [7:0]  w_count_nx;
    logic        w_unused_adr;

    assign w_off        = wb.wbs_adr_i[3:2];
    assign w_unused_adr = ^wb.wbs_adr_i[1:0];
    assign w_hit        = (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign w_req        = wb.wbs_stb_i && wb.wbs_cyc_i && w_hit && !r_ack;
    assign w_wr         = w_req && wb.wbs_we_i;
    assign w_ctrl_wr    = w_wr && (w_off == REG_CTRL);

    assign w_ctrl_new    = merge_bytes(r_ctrl, wb.wbs_dat_i, wb.wbs_sel_i) & CTRL_MASK;
    assign w_div_new     = merge_bytes(r_div, wb.wbs_dat_i, wb.wbs_sel_i) & DIV_MASK;
    assign w_pattern_new = merge_bytes(r_pattern, wb.wbs_dat_i, wb.wbs_sel_i);

    assign w_en      = r_ctrl[CTRL_EN];
    assign w_mode    = r_ctrl[CTRL_MODE];
    assign w_oneshot = r_ctrl[CTRL_ONESHOT];
    assign w_len     = r_ctrl[CTRL_LEN_HI:CTRL_LEN_LO];

    // Changing the source or pattern length mid-run starts the sequence over.
    assign w_restart = (r_state == ST_RUN) && w_ctrl_wr &&
                       ((w_ctrl_new[CTRL_MODE] != r_ctrl[CTRL_MODE]) ||
                        (w_ctrl_new[CTRL_LEN_HI:CTRL_LEN_LO] != w_len));

    assign w_presc_restart = (r_state != ST_RUN) || w_restart;

    assign w_done_clr = w_wr && (w_off == REG_STATUS) && wb.wbs_sel_i[0] &&
                        wb.wbs_dat_i[STAT_DONE];

    heartbeat_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .nreset  (nreset),
        .restart (w_presc_restart),
        .div     (r_div[DIV_WIDTH-1:0]),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_ctrl    <= '0;
            r_div     <= '0;
            r_pattern <= '0;
        end else if (w_wr) begin
            case (w_off)
                REG_CTRL:    r_ctrl    <= w_ctrl_new;
                REG_DIV:     r_div     <= w_div_new;
                REG_PATTERN: r_pattern <= w_pattern_new;
                default:     ;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            REG_CTRL:    w_rd_data = r_ctrl;
            REG_DIV:     w_rd_data = r_div;
            REG_PATTERN: w_rd_data = r_pattern;
            default:     w_rd_data = status_word(r_state == ST_RUN, r_done, r_idx, r_count);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb.wbs_we_i) ? w_rd_data : '0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_count_nx = r_count;
        w_done_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) begin
                    w_state_nx = ST_RUN;
                    w_idx_nx   = '0;
                    w_count_nx = '0;
                end
            end
            ST_RUN: begin
                if (!w_en) begin
                    w_state_nx = ST_IDLE;
                end else if (w_restart) begin
                    w_idx_nx   = '0;
                    w_count_nx = '0;
                end else if (w_tick) begin
                    if (!w_mode) begin
                        w_count_nx = r_count + 8'd1;
                    end else if (r_idx == w_len) begin
                        w_idx_nx = '0;
                        if (w_oneshot) begin
                            w_state_nx = ST_DONE;
                            w_done_set = 1'b1;
                        end
                    end else begin
                        w_idx_nx = r_idx + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!w_en) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_count <= w_count_nx;
            // A completion in the same cycle as a software clear keeps the flag set.
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign out = (r_state == ST_RUN) && (w_mode ? r_pattern[r_idx] : r_count[7]);
    assign irq = r_done;

endmodule

// File: tb/tb_heartbeat_ctrl.sv
// tb/tb_heartbeat_ctrl.sv - self-checking bench for heartbeat_ctrl
module tb_heartbeat_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [1:0]  O_CTRL = 2'd0, O_DIV = 2'd1, O_PAT = 2'd2, O_STAT = 2'd3;

    logic clk = 1'b0;
    logic nreset;
    logic hb_out;
    logic hb_irq;

    heartbeat_ctrl_if wb_if();

    heartbeat_ctrl #(
        .ADDR_BASE(BASE),
        .DIV_WIDTH(24)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .wb     (wb_if),
        .out    (hb_out),
        .irq    (hb_irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc_cnt  = 0;
    int last_req = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: register contents plus run state (0 idle, 1 run, 2 done)
    logic [31:0] m_ctrl = '0, m_div = '0, m_pat = '0, m_dat = '0;
    logic [31:0] m_elapsed = '0, m_period = '0;
    logic [4:0]  m_idx = '0;
    logic [7:0]  m_count = '0;
    logic        m_done = 1'b0, m_ack = 1'b0;
    int          m_st = 0;

    logic [31:0] n_ctrl, n_div, n_pat, n_el, n_per;
    logic [4:0]  n_idx;
    logic [7:0]  n_count;
    logic        t_req, t_wr, t_tick, t_restart, t_set, t_clr;
    logic [1:0]  t_off;
    int          n_st;
    logic        exp_out;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_ctrl;
            2'd1:    return m_div;
            2'd2:    return m_pat;
            default: return (32'(m_count) << 16) + (32'(m_idx) << 8) +
                            (32'(m_done) << 1) + ((m_st == 1) ? 32'd1 : 32'd0);
        endcase
    endfunction

    always @(posedge clk) begin
        if (!nreset) begin
            m_ctrl <= '0; m_div <= '0; m_pat <= '0; m_dat <= '0;
            m_elapsed <= '0; m_period <= '0; m_idx <= '0; m_count <= '0;
            m_done <= 1'b0; m_ack <= 1'b0; m_st <= 0;
        end else begin
            t_req = wb_if.wbs_stb_i && wb_if.wbs_cyc_i &&
                    (wb_if.wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
            t_wr  = t_req && wb_if.wbs_we_i;
            t_off = wb_if.wbs_adr_i[3:2];
            n_ctrl = m_ctrl; n_div = m_div; n_pat = m_pat;
            if (t_wr && t_off == O_CTRL) n_ctrl = bmerge(m_ctrl, wb_if.wbs_dat_i, wb_if.wbs_sel_i) & 32'h1F7;
            if (t_wr && t_off == O_DIV)  n_div  = bmerge(m_div, wb_if.wbs_dat_i, wb_if.wbs_sel_i) & 32'h00FF_FFFF;
            if (t_wr && t_off == O_PAT)  n_pat  = bmerge(m_pat, wb_if.wbs_dat_i, wb_if.wbs_sel_i);
            t_clr = t_wr && t_off == O_STAT && wb_if.wbs_sel_i[0] && wb_if.wbs_dat_i[1];
            t_restart = t_wr && t_off == O_CTRL &&
                        ((n_ctrl[1] != m_ctrl[1]) || (n_ctrl[8:4] != m_ctrl[8:4]));
            t_tick = (m_elapsed == m_period);
            n_st = m_st; n_idx = m_idx; n_count = m_count; t_set = 1'b0;
            n_el = m_elapsed; n_per = m_period;
            if (m_st == 0) begin
                if (m_ctrl[0]) begin
                    n_st = 1; n_idx = 0; n_count = 0; n_el = 0; n_per = m_div;
                end
            end else if (m_st == 1) begin
                if (!m_ctrl[0]) begin
                    n_st = 0;
                end else if (t_restart) begin
                    n_idx = 0; n_count = 0; n_el = 0; n_per = m_div;
                end else if (t_tick) begin
                    n_el = 0; n_per = m_div;
                    if (!m_ctrl[1]) begin
                        n_count = 8'((int'(m_count) + 1) % 256);
                    end else if (m_idx == m_ctrl[8:4]) begin
                        n_idx = 0;
                        if (m_ctrl[2]) begin
                            n_st = 2; t_set = 1'b1;
                        end
                    end else begin
                        n_idx = m_idx + 5'd1;
                    end
                end else begin
                    n_el = m_elapsed + 32'd1;
                end
            end else if (!m_ctrl[0]) begin
                n_st = 0;
            end
            m_dat <= (t_req && !wb_if.wbs_we_i) ? m_read(t_off) : 32'd0;
            m_ack <= t_req;
            m_ctrl <= n_ctrl; m_div <= n_div; m_pat <= n_pat;
            m_st <= n_st; m_idx <= n_idx; m_count <= n_count;
            m_elapsed <= n_el; m_period <= n_per;
            m_done <= t_set ? 1'b1 : (t_clr ? 1'b0 : m_done);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_out = (m_st == 1) && (m_ctrl[1] ? m_pat[m_idx] : m_count[7]);
            checks++;
            if ({hb_out, hb_irq, wb_if.wbs_ack_o, wb_if.wbs_dat_o} !== {exp_out, m_done, m_ack, m_dat}) begin
                errors++;
                $display("FAIL model_cmp t=%0t out/irq/ack/dat got %b/%b/%b/%h expected %b/%b/%b/%h",
                         $time, hb_out, hb_irq, wb_if.wbs_ack_o, wb_if.wbs_dat_o,
                         exp_out, m_done, m_ack, m_dat);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_we_i = we;
        wb_if.wbs_adr_i = adr;  wb_if.wbs_dat_i = dat;  wb_if.wbs_sel_i = sel;
        acked = 1'b0;
        rdat  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_if.wbs_ack_o === 1'b1) begin
                acked    = 1'b1;
                rdat     = wb_if.wbs_dat_o;
                last_req = cyc_cnt;
                break;
            end
        end
        wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        logic        ok;
        wb_xfer(1'b1, BASE + {28'd0, off, 2'b00}, dat, sel, rd, ok);
        check("write_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_rd_chk(input string name, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ok;
        wb_xfer(1'b0, BASE + {28'd0, off, 2'b00}, 32'd0, 4'hF, rd, ok);
        check({name, "_ack"}, {31'd0, ok}, 32'd1);
        check(name, rd, exp);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc_cnt < target) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        logic [31:0] rd;
        logic        ok;
        nreset = 1'b0;
        wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_we_i = 1'b0;
        wb_if.wbs_sel_i = 4'hF; wb_if.wbs_dat_i = '0; wb_if.wbs_adr_i = BASE + 32'hC;
        @(posedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ack_out_irq", {29'd0, wb_if.wbs_ack_o, hb_out, hb_irq}, 32'd0);
        end
        nreset = 1'b1;
        wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0;

        wb_rd_chk("rst_ctrl", O_CTRL, 32'h0);
        wb_rd_chk("rst_div",  O_DIV,  32'h0);
        wb_rd_chk("rst_pat",  O_PAT,  32'h0);
        wb_rd_chk("rst_stat", O_STAT, 32'h0);

        // Byte-lane write: only byte 0 of 0x1F2 lands (EN=0, MODE=1, LEN[3:0]=F)
        wb_wr(O_CTRL, 32'h0000_01F2, 4'b0001);
        wb_rd_chk("ctrl_sel", O_CTRL, 32'h0000_00F2);
        wb_wr(O_CTRL, 32'h0, 4'hF);
        wb_xfer(1'b0, BASE + 32'h40, 32'd0, 4'hF, rd, ok);
        check("miss_no_ack", {31'd0, ok}, 32'd0);

        // Counter mode, DIV=3: tick k at edge w+1+4k
        wb_wr(O_DIV, 32'd3, 4'hF);
        wb_wr(O_CTRL, 32'h1, 4'hF);
        w = last_req;
        wait_cyc(w + 20);
        wb_rd_chk("cnt_after_5", O_STAT, 32'h0005_0001);
        wait_cyc(w + 512); check("cnt_out_127", {31'd0, hb_out}, 32'd0);
        wait_cyc(w + 513); check("cnt_out_128", {31'd0, hb_out}, 32'd1);
        wait_cyc(w + 1024); check("cnt_out_255", {31'd0, hb_out}, 32'd1);
        wait_cyc(w + 1025); check("cnt_out_256", {31'd0, hb_out}, 32'd0);

        // Pattern repeat 0xA, LEN=3, DIV=0
        wb_wr(O_CTRL, 32'h0, 4'hF);
        wb_wr(O_DIV, 32'd0, 4'hF);
        wb_wr(O_PAT, 32'hA, 4'hF);
        wb_wr(O_CTRL, 32'h33, 4'hF);
        w = last_req;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(w + k);
            check("pat_repeat_out", {31'd0, hb_out}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        wb_rd_chk("pat_busy", O_STAT, 32'h0000_0001);

        // One-shot 0xF, LEN=1, DIV=1
        wb_wr(O_CTRL, 32'h0, 4'hF);
        wb_wr(O_DIV, 32'd1, 4'hF);
        wb_wr(O_PAT, 32'hF, 4'hF);
        wb_wr(O_CTRL, 32'h17, 4'hF);
        w = last_req;
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(w + k);
            check("oneshot_high", {30'd0, hb_out, hb_irq}, 32'd2);
        end
        wait_cyc(w + 5);
        check("oneshot_done", {30'd0, hb_out, hb_irq}, 32'd1);
        wb_wr(O_STAT, 32'h2, 4'b0001);
        check("w1c_clears", {31'd0, hb_irq}, 32'd0);
        wb_wr(O_CTRL, 32'h0, 4'hF);
        wb_wr(O_CTRL, 32'h17, 4'hF);
        w = last_req;
        wait_cyc(w + 3);
        wb_wr(O_STAT, 32'h2, 4'b0001);
        check("w1c_same_edge", last_req, w + 5);
        check("set_wins", {31'd0, hb_irq}, 32'd1);
        wb_wr(O_STAT, 32'h2, 4'b0001);

        // Clear EN mid-run
        wb_wr(O_CTRL, 32'h0, 4'hF);
        wb_wr(O_PAT, 32'hFFFF_FFFF, 4'hF);
        wb_wr(O_DIV, 32'd0, 4'hF);
        wb_wr(O_CTRL, 32'h3, 4'hF);
        wait_cyc(last_req + 3);
        check("run_out_high", {31'd0, hb_out}, 32'd1);
        wb_wr(O_CTRL, 32'h2, 4'hF);
        w = last_req;
        check("en_clr_same", {31'd0, hb_out}, 32'd1);
        wait_cyc(w + 1);
        check("en_clr_next", {31'd0, hb_out}, 32'd0);

        // MODE change mid-run restarts idx/count
        wb_wr(O_CTRL, 32'h1, 4'hF);
        wait_cyc(last_req + 12);
        wb_rd_chk("cnt_running", O_STAT, 32'h000C_0001);
        wb_wr(O_CTRL, 32'h33, 4'hF);
        wb_rd_chk("mode_restart", O_STAT, 32'h0000_0101);

        // Reset pulse mid-run with a request on the bus
        @(negedge clk);
        nreset = 1'b0;
        wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_adr_i = BASE;
        @(negedge clk);
        check("midrst_outs", {29'd0, wb_if.wbs_ack_o, hb_out, hb_irq}, 32'd0);
        nreset = 1'b1;
        wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0;
        wb_rd_chk("midrst_ctrl", O_CTRL, 32'h0);
        wb_rd_chk("midrst_div",  O_DIV,  32'h0);
        wb_rd_chk("midrst_pat",  O_PAT,  32'h0);
        wb_rd_chk("midrst_stat", O_STAT, 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
